// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg : shared types and default sizes for the PC sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned c_PC_W_DEF       = 12;
  localparam int unsigned c_IDX_W_DEF      = 8;
  localparam int unsigned c_CNT_W_DEF      = 16;
  localparam int unsigned c_START_ADDR_DEF = 0;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter : up-counter with synchronous clear that sticks at all-ones
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer : program counter owner; start/done handshake, stall, halt,
//                LUT absolute jumps and PC-relative branches
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned D          = c_PC_W_DEF,
  parameter int unsigned IDX_W      = c_IDX_W_DEF,
  parameter int unsigned CNT_W      = c_CNT_W_DEF,
  parameter int unsigned START_ADDR = c_START_ADDR_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             halt,
  input  logic             jump_abs,
  input  logic             jump_rel,
  input  logic             cond,
  input  logic [IDX_W-1:0] lut_idx_in,
  input  logic [7:0]       rel_off,
  output logic [IDX_W-1:0] lut_addr,
  input  logic [D-1:0]     lut_target,
  output logic [D-1:0]     pc,
  output logic             fetch_en,
  output logic             done,
  output logic [CNT_W-1:0] run_cycles
);

  // Relative math is done at least 8 bits wide so the offset keeps its sign.
  localparam int unsigned c_EXT_W = (D > 8) ? D : 8;

  state_e             state_q, state_d;
  logic [D-1:0]       pc_q, pc_d;
  logic [c_EXT_W-1:0] w_off_ext;
  logic [c_EXT_W-1:0] w_rel_sum;
  logic [D-1:0]       w_rel_pc;
  logic               w_arm;

  assign w_off_ext = c_EXT_W'($signed(rel_off));
  assign w_rel_sum = c_EXT_W'(pc_q) + w_off_ext;
  assign w_rel_pc  = w_rel_sum[D-1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ARMED;
          pc_d    = D'(START_ADDR);
        end
      end
      ST_ARMED: begin
        pc_d = D'(START_ADDR);
        if (!start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          if (halt) begin
            state_d = ST_DONE;
          end else if (jump_abs && cond) begin
            pc_d = lut_target;
          end else if (jump_rel && cond) begin
            pc_d = w_rel_pc;
          end else begin
            pc_d = pc_q + D'(1);
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_ARMED;
          pc_d    = D'(START_ADDR);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= D'(START_ADDR);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Clearing on the arming edge means the count is already zero in ARMED.
  assign w_arm = (state_d == ST_ARMED);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_run_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (w_arm),
    .en_i    (state_q == ST_RUN),
    .count_o (run_cycles)
  );

  assign lut_addr = lut_idx_in;
  assign pc       = pc_q;
  assign fetch_en = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer : directed scenarios plus random stimulus against a
//                   behavioural model of the PC sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;

  localparam int D       = 12;
  localparam int IDX_W   = 8;
  localparam int CNT_W   = 4;
  localparam int PC_MOD  = 1 << D;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;

  logic             clk;
  logic             rst_n;
  logic             start, stall, halt, jump_abs, jump_rel, cond;
  logic [IDX_W-1:0] lut_idx_in;
  logic [7:0]       rel_off;
  logic [IDX_W-1:0] lut_addr;
  logic [D-1:0]     lut_target;
  logic [D-1:0]     pc;
  logic             fetch_en;
  logic             done;
  logic [CNT_W-1:0] run_cycles;

  logic [D-1:0] lut_mem [1 << IDX_W];

  int n_checks;
  int n_fail;
  int m_mode;
  int m_pc;
  int m_cyc;

  pc_sequencer #(
    .D          (D),
    .IDX_W      (IDX_W),
    .CNT_W      (CNT_W),
    .START_ADDR (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stall      (stall),
    .halt       (halt),
    .jump_abs   (jump_abs),
    .jump_rel   (jump_rel),
    .cond       (cond),
    .lut_idx_in (lut_idx_in),
    .rel_off    (rel_off),
    .lut_addr   (lut_addr),
    .lut_target (lut_target),
    .pc         (pc),
    .fetch_en   (fetch_en),
    .done       (done),
    .run_cycles (run_cycles)
  );

  assign lut_target = lut_mem[lut_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_pc   = 0;
    m_cyc  = 0;
  endtask

  task automatic model_arm();
    m_mode = M_ARMED;
    m_pc   = 0;
    m_cyc  = 0;
  endtask

  task automatic model_step();
    case (m_mode)
      M_IDLE:  if (start) model_arm();
      M_ARMED: if (!start) m_mode = M_RUN;
      M_RUN: begin
        m_cyc = (m_cyc < CNT_MAX) ? m_cyc + 1 : CNT_MAX;
        if (!stall) begin
          if (halt)                  m_mode = M_DONE;
          else if (jump_abs && cond) m_pc = int'(lut_mem[lut_idx_in]);
          else if (jump_rel && cond) m_pc = ((m_pc + int'($signed(rel_off))) % PC_MOD + PC_MOD) % PC_MOD;
          else                       m_pc = (m_pc + 1) % PC_MOD;
        end
      end
      default: if (start) model_arm();
    endcase
  endtask

  task automatic check_all();
    chk("pc",         32'(pc),         32'(m_pc));
    chk("fetch_en",   32'(fetch_en),   32'(m_mode == M_RUN));
    chk("done",       32'(done),       32'(m_mode == M_DONE));
    chk("run_cycles", 32'(run_cycles), 32'(m_cyc));
    chk("lut_addr",   32'(lut_addr),   32'(lut_idx_in));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic clear_in();
    start = 0; stall = 0; halt = 0; jump_abs = 0; jump_rel = 0; cond = 0;
    lut_idx_in = '0; rel_off = '0;
  endtask

  // Reset is pulsed between clock edges so the response must be asynchronous.
  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_pc",       32'(pc),         32'd0);
    chk("arst_fetch_en", 32'(fetch_en),   32'd0);
    chk("arst_done",     32'(done),       32'd0);
    chk("arst_cycles",   32'(run_cycles), 32'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_in();
    rst_n = 1'b0;
    for (int i = 0; i < (1 << IDX_W); i++) lut_mem[i] = D'($urandom);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pc",       32'(pc),         32'd0);
    chk("rst_fetch_en", 32'(fetch_en),   32'd0);
    chk("rst_done",     32'(done),       32'd0);
    chk("rst_cycles",   32'(run_cycles), 32'd0);
    rst_n = 1'b1;

    // Arm for three cycles, run on start falling edge
    start = 1;
    repeat (3) cyc();
    chk("t1_armed_pc", 32'(pc), 32'd0);
    chk("t1_armed_fe", 32'(fetch_en), 32'd0);
    start = 0;
    cyc();
    chk("t1_run_fe", 32'(fetch_en), 32'd1);
    chk("t1_run_pc0", 32'(pc), 32'd0);
    repeat (3) cyc();
    chk("t1_pc3", 32'(pc), 32'd3);
    chk("t1_done", 32'(done), 32'd0);
    repeat (2) cyc();
    chk("t2_pc5", 32'(pc), 32'd5);

    // Absolute jump through the LUT
    lut_mem[1] = D'(17);
    jump_abs = 1; cond = 1; lut_idx_in = 8'd1;
    #1 chk("t2_lut_addr", 32'(lut_addr), 32'd1);
    cyc();
    chk("t2_pc17", 32'(pc), 32'd17);
    clear_in();
    repeat (3) cyc();
    chk("t3_pc20", 32'(pc), 32'd20);

    // Relative branch, taken and not taken
    jump_rel = 1; cond = 1; rel_off = 8'hFC;
    cyc();
    chk("t3_rel_taken", 32'(pc), 32'd16);
    clear_in();
    repeat (4) cyc();
    jump_rel = 1; cond = 0; rel_off = 8'hFC;
    cyc();
    chk("t3_rel_not_taken", 32'(pc), 32'd21);
    clear_in();

    // Both jumps taken: absolute wins; then wrap at the top of the space
    lut_mem[2] = D'(PC_MOD - 1);
    jump_abs = 1; jump_rel = 1; cond = 1; lut_idx_in = 8'd2; rel_off = 8'd3;
    cyc();
    chk("t5_abs_wins", 32'(pc), 32'(PC_MOD - 1));
    clear_in();
    cyc();
    chk("t5_wrap", 32'(pc), 32'd0);

    // Stall masks halt
    repeat (8) cyc();
    chk("t4_pc8", 32'(pc), 32'd8);
    stall = 1; halt = 1;
    repeat (2) cyc();
    chk("t4_stall_pc", 32'(pc), 32'd8);
    chk("t4_stall_fe", 32'(fetch_en), 32'd1);
    stall = 0;
    cyc();
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_done_fe", 32'(fetch_en), 32'd0);
    chk("t4_done_pc", 32'(pc), 32'd8);
    chk("t4_cycles_sat", 32'(run_cycles), 32'(CNT_MAX));
    halt = 0;
    cyc();
    chk("t4_frozen_pc", 32'(pc), 32'd8);

    // Rerun, reach pc=40, then reset mid-run and restart
    start = 1;
    cyc();
    chk("rerun_pc", 32'(pc), 32'd0);
    chk("rerun_cycles", 32'(run_cycles), 32'd0);
    chk("rerun_done", 32'(done), 32'd0);
    start = 0;
    cyc();
    lut_mem[3] = D'(40);
    jump_abs = 1; cond = 1; lut_idx_in = 8'd3;
    cyc();
    clear_in();
    chk("t6_pc40", 32'(pc), 32'd40);
    async_reset();
    start = 1;
    cyc();
    start = 0;
    cyc();
    cyc();
    chk("t6_restart_pc1", 32'(pc), 32'd1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      start      = ($urandom_range(0, 9) == 0);
      stall      = ($urandom_range(0, 4) == 0);
      halt       = ($urandom_range(0, 19) == 0);
      jump_abs   = ($urandom_range(0, 3) == 0);
      jump_rel   = ($urandom_range(0, 3) == 0);
      cond       = 1'($urandom);
      lut_idx_in = IDX_W'($urandom);
      rel_off    = 8'($urandom);
      if ($urandom_range(0, 7) == 0) lut_mem[$urandom_range(0, (1 << IDX_W) - 1)] = D'($urandom);
      if ($urandom_range(0, 199) == 0) async_reset();
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
